// File: rtl/vga_pkg.sv
// Shared timing defaults, state encoding and pixel bundle
// for the VGA timing controller and its counter.
package vga_pkg;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FP_DEF     = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BP_DEF     = 48;
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FP_DEF     = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BP_DEF     = 33;
   localparam logic        SYNC_POL_DEF = 1'b0;

   function automatic int unsigned span_total(
      input int unsigned act,
      input int unsigned fp,
      input int unsigned sync,
      input int unsigned bp
   );
      return act + fp + sync + bp;
   endfunction

   localparam int unsigned H_TOTAL_DEF =
      span_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
   localparam int unsigned V_TOTAL_DEF =
      span_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } vga_state_e;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

endpackage

// File: rtl/vga_if.sv
// Pin bundle towards an ADV7123-style video DAC.
interface tIVgaDriver;

   logic [7:0] ul8VgaRed;
   logic [7:0] ul8VgaGreen;
   logic [7:0] ul8VgaBlue;
   logic       ul1VgaBlank_n;
   logic       ul1VgaSync_n;
   logic       ul1VgaHSync;
   logic       ul1VgaVSync;
   logic       ul1VgaClock;

   modport driver (
      output ul8VgaRed,
      output ul8VgaGreen,
      output ul8VgaBlue,
      output ul1VgaBlank_n,
      output ul1VgaSync_n,
      output ul1VgaHSync,
      output ul1VgaVSync,
      output ul1VgaClock
   );

   modport dac (
      input ul8VgaRed,
      input ul8VgaGreen,
      input ul8VgaBlue,
      input ul1VgaBlank_n,
      input ul1VgaSync_n,
      input ul1VgaHSync,
      input ul1VgaVSync,
      input ul1VgaClock
   );

endinterface

// File: rtl/vga_timing_counter.sv
// Horizontal/vertical raster counters with active and
// sync region decode; counters sit at 0,0 while not running.
module vga_timing_counter
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FP     = H_FP_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BP     = H_BP_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FP     = V_FP_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BP     = V_BP_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic run_i,
   output logic act_o,
   output logic hs_o,
   output logic vs_o,
   output logic first_o,
   output logic last_o
);

   localparam int unsigned H_TOTAL =
      span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL =
      span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   // One spare state so sync-end bounds equal to the total still fit.
   localparam int unsigned HW = $clog2(H_TOTAL + 1);
   localparam int unsigned VW = $clog2(V_TOTAL + 1);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);

   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic          h_end;
   logic          v_end;

   assign h_end = (h_q == H_LAST);
   assign v_end = (v_q == V_LAST);

   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (!run_i) begin
         h_d = '0;
         v_d = '0;
      end else if (h_end) begin
         h_d = '0;
         v_d = v_end ? '0 : v_q + 1'b1;
      end else begin
         h_d = h_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   assign act_o   = run_i & (h_q < H_ACT) & (v_q < V_ACT);
   assign hs_o    = run_i & (h_q >= HS_BEG) & (h_q < HS_END);
   assign vs_o    = run_i & (v_q >= VS_BEG) & (v_q < VS_END);
   assign first_o = run_i & (h_q == '0) & (v_q == '0);
   assign last_o  = run_i & h_end & v_end;

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster controller: run/idle FSM, pixel handshake,
// underrun flag and registered DAC pin drive.
module vga_timing_controller
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FP     = H_FP_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BP     = H_BP_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FP     = V_FP_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BP     = V_BP_DEF,
   parameter logic        SYNC_POL = SYNC_POL_DEF
) (
   input  logic        ul1Clock,
   input  logic        ul1Reset,
   input  logic        ul1Enable,
   input  logic [23:0] ul24PixelData,
   input  logic        ul1PixelValid,
   output logic        ul1PixelReady,
   output logic        ul1FrameStart,
   output logic        ul1Underrun,
   input  logic        ul1UnderrunClear,
   output logic        ul1Busy,
   tIVgaDriver.driver  vga
);

   vga_state_e state_q, state_d;

   logic run;
   logic act;
   logic hs;
   logic vs;
   logic first;
   logic last;
   logic xfer;

   rgb_t rgb_q, rgb_d;
   logic blank_q, blank_d;
   logic hs_q, hs_d;
   logic vs_q, vs_d;
   logic und_q, und_d;

   assign run = (state_q == RUN);

   vga_timing_counter #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_cnt (
      .clk_i   (ul1Clock),
      .rst_i   (ul1Reset),
      .run_i   (run),
      .act_o   (act),
      .hs_o    (hs),
      .vs_o    (vs),
      .first_o (first),
      .last_o  (last)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (ul1Enable) state_d = RUN;
         RUN:  if (last && !ul1Enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign xfer = act & ul1PixelValid;

   // A missing pixel still shows as black active video; the slot is lost.
   always_comb begin
      rgb_d   = '0;
      blank_d = act;
      hs_d    = hs ? SYNC_POL : ~SYNC_POL;
      vs_d    = vs ? SYNC_POL : ~SYNC_POL;
      und_d   = und_q;
      if (xfer) rgb_d = rgb_t'(ul24PixelData);
      if (act && !ul1PixelValid) und_d = 1'b1;
      else if (ul1UnderrunClear) und_d = 1'b0;
   end

   always_ff @(posedge ul1Clock) begin
      if (ul1Reset) begin
         state_q <= IDLE;
         rgb_q   <= '0;
         blank_q <= 1'b0;
         hs_q    <= ~SYNC_POL;
         vs_q    <= ~SYNC_POL;
         und_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rgb_q   <= rgb_d;
         blank_q <= blank_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         und_q   <= und_d;
      end
   end

   assign ul1PixelReady = act;
   assign ul1FrameStart = first;
   assign ul1Underrun   = und_q;
   assign ul1Busy       = run;

   assign vga.ul8VgaRed     = rgb_q.r;
   assign vga.ul8VgaGreen   = rgb_q.g;
   assign vga.ul8VgaBlue    = rgb_q.b;
   assign vga.ul1VgaBlank_n = blank_q;
   assign vga.ul1VgaHSync   = hs_q;
   assign vga.ul1VgaVSync   = vs_q;
   // Inverted clock puts the DAC sampling edge mid-data.
   assign vga.ul1VgaClock   = ~ul1Clock;
   assign vga.ul1VgaSync_n  = 1'b0;

endmodule
